// File: rtl/pulse_period_meter.sv
// pulse_period_meter: measures clk-cycle interval between event pulses and
// hands each result out over valid/ready; flags timeouts and dropped results.
// Ports: clk, rst_n (async, active-low), enable, pulse_in,
//        period_data/period_valid/period_ready (result handshake),
//        timeout, overrun (status), clr_status (sticky-flag clear).
// Optional macro PULSE_METER_STICKY_EN: timeout/overrun become sticky flags
// cleared by clr_status; otherwise they are one-cycle pulses.
module pulse_period_meter #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] period_data,
    output logic             period_valid,
    input  logic             period_ready,
    output logic             timeout,
    output logic             overrun,
    input  logic             clr_status
);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             new_res;
    logic             tmo_evt;
    logic             ovr_evt;

    // A pulse closes an interval only while measuring; a pulse on the
    // timeout cycle still counts as a result rather than a timeout.
    always_comb begin
        new_res = 1'b0;
        tmo_evt = 1'b0;
        ovr_evt = 1'b0;
        if (state == MEASURE && enable) begin
            new_res = pulse_in;
            tmo_evt = !pulse_in && (cnt == TMO);
        end
        ovr_evt = new_res && period_valid && !period_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            period_data  <= '0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (enable && pulse_in) begin
                        state <= MEASURE;
                        cnt   <= ONE;
                    end
                end
                MEASURE: begin
                    if (!enable) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (pulse_in) begin
                        cnt <= ONE;
                    end else if (tmo_evt) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase

            // Output slot: a new result may replace one being accepted this
            // cycle; otherwise it is dropped while the old one is held.
            if (new_res && (!period_valid || period_ready)) begin
                period_data  <= cnt;
                period_valid <= 1'b1;
            end else if (period_valid && period_ready) begin
                period_valid <= 1'b0;
            end

`ifdef PULSE_METER_STICKY_EN
            if (clr_status) begin
                timeout <= 1'b0;
                overrun <= 1'b0;
            end else begin
                if (tmo_evt) timeout <= 1'b1;
                if (ovr_evt) overrun <= 1'b1;
            end
`else
            timeout <= tmo_evt;
            overrun <= ovr_evt;
`endif
        end
    end

`ifndef PULSE_METER_STICKY_EN
    logic unused_clr;
    assign unused_clr = clr_status;
`endif

endmodule

// File: tb/tb_pulse_period_meter.sv
// Testbench for pulse_period_meter: scoreboard of expected periods checked
// at each accepted result, plus per-scenario status and timing checks.
module tb_pulse_period_meter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        pulse_in;
    logic [15:0] period_data;
    logic        period_valid;
    logic        period_ready;
    logic        timeout;
    logic        overrun;
    logic        clr_status;

    int n_cmp = 0;
    int n_err = 0;
    int q[$];

`ifdef PULSE_METER_STICKY_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    pulse_period_meter #(.CNT_W(16), .TIMEOUT(20)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .pulse_in    (pulse_in),
        .period_data (period_data),
        .period_valid(period_valid),
        .period_ready(period_ready),
        .timeout     (timeout),
        .overrun     (overrun),
        .clr_status  (clr_status)
    );

    always #5 clk = ~clk;

    // scoreboard: every accepted result pops one expected period
    always @(negedge clk) begin
        if (rst_n && period_valid && period_ready) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got %0d, expected none",
                         period_data);
            end else begin
                int e;
                e = q.pop_front();
                if (period_data !== 16'(e)) begin
                    n_err++;
                    $display("FAIL sb_data: got %0d, expected %0d",
                             period_data, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        pulse_in = 1'b1;
        tick();
        pulse_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic drain();
        enable       = 1'b0;
        pulse_in     = 1'b0;
        period_ready = 1'b1;
        clr_status   = 1'b1;
        tick();
        clr_status = 1'b0;
        tick();
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: got %0d pending, expected 0",
                     q.size());
        end
        q.delete();
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        enable       = 1'b0;
        pulse_in     = 1'b0;
        period_ready = 1'b0;
        clr_status   = 1'b0;
        #3;
        n_cmp++;
        if ({period_data, period_valid, timeout, overrun} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_out: got %h, expected 0",
                     {period_data, period_valid, timeout, overrun});
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        enable       = 1'b1;
        period_ready = 1'b1;
        pulse();
        n_cmp++;
        if (period_valid !== 1'b0) begin
            n_err++;
            $display("FAIL first_pulse_valid: got %b, expected 0",
                     period_valid);
        end
        idle(8);
        q.push_back(9);
        pulse();
        n_cmp++;
        if (period_valid !== 1'b1) begin
            n_err++;
            $display("FAIL basic_valid1: got %b, expected 1", period_valid);
        end
        tick();
        n_cmp++;
        if (period_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_drop1: got %b, expected 0", period_valid);
        end
        idle(8);
        q.push_back(10);
        pulse();
        n_cmp++;
        if (period_valid !== 1'b1) begin
            n_err++;
            $display("FAIL basic_valid2: got %b, expected 1", period_valid);
        end
        tick();
        n_cmp++;
        if (period_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_drop2: got %b, expected 0", period_valid);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        enable       = 1'b1;
        period_ready = 1'b1;
        pulse();
        q.push_back(1);
        pulse();
        q.push_back(1);
        pulse();
        n_cmp++;
        if ({period_valid, period_data, overrun} !== {1'b1, 16'd1, 1'b0}) begin
            n_err++;
            $display("FAIL b2b_stream: got v=%b d=%0d o=%b, expected v=1 d=1 o=0",
                     period_valid, period_data, overrun);
        end
        tick();
        n_cmp++;
        if ({period_valid, overrun} !== 2'b00) begin
            n_err++;
            $display("FAIL b2b_end: got v=%b o=%b, expected 0 0",
                     period_valid, overrun);
        end
        drain();
    endtask

    task automatic test_timeout();
        enable       = 1'b1;
        period_ready = 1'b1;
        pulse();
        idle(19);
        n_cmp++;
        if (timeout !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_early: got %b, expected 0", timeout);
        end
        tick();
        n_cmp++;
        if (timeout !== 1'b1) begin
            n_err++;
            $display("FAIL tmo_fire: got %b, expected 1", timeout);
        end
        tick();
        n_cmp++;
        if (timeout !== STICKY) begin
            n_err++;
            $display("FAIL tmo_after: got %b, expected %b", timeout, STICKY);
        end
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        pulse();
        n_cmp++;
        if (period_valid !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_restart: got %b, expected 0", period_valid);
        end
        idle(4);
        q.push_back(5);
        pulse();
        n_cmp++;
        if (period_valid !== 1'b1) begin
            n_err++;
            $display("FAIL tmo_next: got %b, expected 1", period_valid);
        end
        idle(19);
        q.push_back(20);
        pulse();
        n_cmp++;
        if ({period_valid, timeout} !== 2'b10) begin
            n_err++;
            $display("FAIL tmo_edge: got v=%b t=%b, expected v=1 t=0",
                     period_valid, timeout);
        end
        drain();
    endtask

    task automatic test_backpressure();
        enable       = 1'b1;
        period_ready = 1'b0;
        pulse();
        idle(4);
        q.push_back(5);
        pulse();
        n_cmp++;
        if ({period_valid, period_data} !== {1'b1, 16'd5}) begin
            n_err++;
            $display("FAIL bp_load: got v=%b d=%0d, expected v=1 d=5",
                     period_valid, period_data);
        end
        idle(3);
        n_cmp++;
        if ({period_valid, period_data, overrun} !== {1'b1, 16'd5, 1'b0}) begin
            n_err++;
            $display("FAIL bp_hold: got v=%b d=%0d o=%b, expected v=1 d=5 o=0",
                     period_valid, period_data, overrun);
        end
        idle(3);
        pulse();
        n_cmp++;
        if ({overrun, period_data} !== {1'b1, 16'd5}) begin
            n_err++;
            $display("FAIL bp_overrun: got o=%b d=%0d, expected o=1 d=5",
                     overrun, period_data);
        end
        tick();
        n_cmp++;
        if (overrun !== STICKY) begin
            n_err++;
            $display("FAIL bp_ovr_after: got %b, expected %b", overrun, STICKY);
        end
        enable       = 1'b0;
        tick();
        n_cmp++;
        if (period_valid !== 1'b1) begin
            n_err++;
            $display("FAIL bp_no_flush: got %b, expected 1", period_valid);
        end
        period_ready = 1'b1;
        tick();
        n_cmp++;
        if (period_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_consume: got %b, expected 0", period_valid);
        end
        drain();
    endtask

    task automatic test_clr_status();
        enable       = 1'b1;
        period_ready = 1'b0;
        pulse();
        idle(1);
        q.push_back(2);
        pulse();
        idle(1);
        clr_status = 1'b1;
        pulse();
        clr_status = 1'b0;
        n_cmp++;
        if (overrun !== !STICKY) begin
            n_err++;
            $display("FAIL clr_vs_set: got %b, expected %b", overrun, !STICKY);
        end
        pulse();
        idle(3);
        n_cmp++;
        if (overrun !== STICKY) begin
            n_err++;
            $display("FAIL ovr_persist: got %b, expected %b", overrun, STICKY);
        end
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_clear: got %b, expected 0", overrun);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        enable       = 1'b1;
        period_ready = 1'b0;
        pulse();
        idle(2);
        q.push_back(3);
        pulse();
        n_cmp++;
        if (period_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rm_pending: got %b, expected 1", period_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({period_data, period_valid, timeout, overrun} !== 19'd0) begin
            n_err++;
            $display("FAIL rm_async: got %h, expected 0",
                     {period_data, period_valid, timeout, overrun});
        end
        q.delete();
        tick();
        rst_n        = 1'b1;
        period_ready = 1'b1;
        pulse();
        idle(2);
        enable = 1'b0;
        pulse();
        enable = 1'b1;
        pulse();
        n_cmp++;
        if (period_valid !== 1'b0) begin
            n_err++;
            $display("FAIL en_restart: got %b, expected 0", period_valid);
        end
        idle(2);
        q.push_back(3);
        pulse();
        n_cmp++;
        if ({period_valid, period_data} !== {1'b1, 16'd3}) begin
            n_err++;
            $display("FAIL en_result: got v=%b d=%0d, expected v=1 d=3",
                     period_valid, period_data);
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_timeout();
        test_backpressure();
        test_clr_status();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
